instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 125 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit with redirect and kill handling
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] instr_buf, instr_buf_n;
    logic [31:0] id_pc_q, id_pc_n;
    logic [31:0] fetch_count_q, fetch_count_n;
    logic        kill, kill_n;
    logic [31:0] redirect_target;

    assign redirect_target = redirect_pc & ALIGN_MASK;

    // Outputs decode from state; reset forces both valids low in the same cycle.
    assign imem_req_valid = rst_n && (state == S_REQ);
    assign imem_req_addr  = pc;
    assign id_valid       = rst_n && (state == S_HOLD);
    assign id_instruction = instr_buf;
    assign id_pc          = id_pc_q;
    assign fetch_count    = fetch_count_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_REQ;
            pc            <= RESET_PC & ALIGN_MASK;
            instr_buf     <= 32'h0;
            id_pc_q       <= 32'h0;
            fetch_count_q <= 32'h0;
            kill          <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            instr_buf     <= instr_buf_n;
            id_pc_q       <= id_pc_n;
            fetch_count_q <= fetch_count_n;
            kill          <= kill_n;
        end
    end

    // Next-state logic; a redirect wins over every other event in the cycle.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_buf_n   = instr_buf;
        id_pc_n       = id_pc_q;
        fetch_count_n = fetch_count_q;
        kill_n        = kill;
        case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_n = redirect_target;
                    if (imem_req_ready) begin
                        // The accepted request targets the stale pc; drop its response.
                        state_n = S_WAIT;
                        kill_n  = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_n = redirect_target;
                    if (imem_rsp_valid) begin
                        state_n = S_REQ;
                        kill_n  = 1'b0;
                    end else begin
                        kill_n  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill) begin
                        state_n = S_REQ;
                        kill_n  = 1'b0;
                    end else begin
                        // Snapshot pc with the data so id_pc stays put after pc advances.
                        instr_buf_n = imem_rsp_data;
                        id_pc_n     = pc;
                        state_n     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_n    = redirect_target;
                    state_n = S_REQ;
                end else if (id_ready) begin
                    pc_n          = pc + 32'd4;
                    fetch_count_n = fetch_count_q + 32'd1;
                    state_n       = S_REQ;
                end
            end
            default: begin
                state_n = S_REQ;
                kill_n  = 1'b0;
            end
        endcase
    end

endmodule
